// File: rtl/ibuf_skew_fifo.sv
// ibuf_skew_fifo: activation input buffer for the systolic array west edge.
// A DEPTH-deep FIFO of ARRAY_SIZE-lane vectors. A step pops one vector and
// injects it diagonally: lane i reaches the array i steps after lane 0. Each
// lane carries a zero flag so the PEs can gate MACs on zero operands.
// Optional feature: define ZERO_SKIP_EN to drop all-zero vectors at write
// time and count them in skip_cnt. When it is undefined, every accepted write
// is stored and skip_cnt is tied to zero.
module ibuf_skew_fifo #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             nRST,
    input  logic                             flush,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [ARRAY_SIZE*DATA_W-1:0]     wr_data,
    input  logic                             step,
    output logic [ARRAY_SIZE-1:0]            out_valid,
    output logic [ARRAY_SIZE*DATA_W-1:0]     out_data,
    output logic [ARRAY_SIZE-1:0]            out_zero,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic [CNT_W-1:0]                 skip_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int VW = ARRAY_SIZE*DATA_W;

    logic [VW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          store;
    logic          pop;
    logic [VW-1:0] rd_data;

    // No full-bypass: a pop in the same cycle does not open the write port.
    assign wr_ready = (count != CW'(DEPTH));
    // flush overrides every data movement in its cycle.
    assign push     = wr_valid && wr_ready && !flush;
    assign pop      = step && (count != '0) && !flush;
    assign rd_data  = mem[rd_ptr];

`ifdef ZERO_SKIP_EN
    logic all_zero;

    // Saturating increment for the dropped-vector counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign all_zero = (wr_data == '0);
    assign store    = push && !all_zero;

    // Count accepted all-zero writes; kept across flush, cleared by reset.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            skip_cnt <= '0;
        end else if (push && all_zero) begin
            skip_cnt <= sat_inc(skip_cnt);
        end
    end
`else
    assign store    = push;
    assign skip_cnt = '0;
`endif

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!nRST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({store, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Skew pipe: lane i owns an (i+1)-stage chain that advances only on step.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        logic [DATA_W-1:0] lane_rd;
        logic [DATA_W-1:0] data_p [0:i];
        logic              vld_p  [0:i];
        logic              zero_p [0:i];

        assign lane_rd = rd_data[i*DATA_W +: DATA_W];

        // Stage 0 captures the popped lane (or a bubble); later stages shift.
        always_ff @(posedge clk) begin
            if (!nRST || flush) begin
                for (int j = 0; j <= i; j++) begin
                    data_p[j] <= '0;
                    vld_p[j]  <= 1'b0;
                    zero_p[j] <= 1'b0;
                end
            end else if (step) begin
                data_p[0] <= pop ? lane_rd : '0;
                vld_p[0]  <= pop;
                zero_p[0] <= pop && (lane_rd == '0);
                for (int j = 1; j <= i; j++) begin
                    data_p[j] <= data_p[j-1];
                    vld_p[j]  <= vld_p[j-1];
                    zero_p[j] <= zero_p[j-1];
                end
            end
        end

        assign out_valid[i]                  = vld_p[i];
        assign out_data[i*DATA_W +: DATA_W]  = data_p[i];
        assign out_zero[i]                   = zero_p[i];
    end

endmodule

// File: tb/tb_ibuf_skew_fifo.sv
// Directed self-checking bench for ibuf_skew_fifo (default parameters).
module tb_ibuf_skew_fifo;

    localparam int AS = 4;
    localparam int DW = 32;
    localparam int DP = 8;
    localparam int CN = 16;

    logic               clk = 1'b0;
    logic               nRST;
    logic               flush;
    logic               wr_valid;
    logic               wr_ready;
    logic [AS*DW-1:0]   wr_data;
    logic               step;
    logic [AS-1:0]      out_valid;
    logic [AS*DW-1:0]   out_data;
    logic [AS-1:0]      out_zero;
    logic [3:0]         count;
    logic [CN-1:0]      skip_cnt;

    int tests = 0;
    int fails = 0;

    ibuf_skew_fifo #(.ARRAY_SIZE(AS), .DATA_W(DW), .DEPTH(DP), .CNT_W(CN)) dut (
        .clk(clk), .nRST(nRST), .flush(flush), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_data(wr_data), .step(step),
        .out_valid(out_valid), .out_data(out_data), .out_zero(out_zero),
        .count(count), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane(input int i);
        return out_data[i*DW +: DW];
    endfunction

    function automatic logic [AS*DW-1:0] vec(input int a0, input int a1, input int a2, input int a3);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    initial begin
        nRST = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; step = 1'b0;
        tick(); tick();
        nRST = 1'b1;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data[63:0], 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_count", count, 0);
        check("rst_skip_cnt", skip_cnt, 0);

        // 1: diagonal injection of two vectors
        wr_valid = 1'b1; wr_data = vec(1, 2, 3, 4); tick();
        wr_data = vec(5, 6, 7, 8); tick();
        wr_valid = 1'b0;
        check("t1_count2", count, 2);
        step = 1'b1;
        tick();
        check("t1_s1_valid", out_valid, 4'b0001);
        check("t1_s1_lane0", lane(0), 1);
        tick();
        check("t1_s2_valid", out_valid, 4'b0011);
        check("t1_s2_lane0", lane(0), 5);
        check("t1_s2_lane1", lane(1), 2);
        tick();
        check("t1_s3_valid", out_valid, 4'b0110);
        check("t1_s3_lane0_bubble", lane(0), 0);
        check("t1_s3_lane2", lane(2), 3);
        tick();
        check("t1_s4_valid", out_valid, 4'b1100);
        check("t1_s4_lane3", lane(3), 4);
        check("t1_s4_lane2", lane(2), 7);
        tick();
        check("t1_s5_valid", out_valid, 4'b1000);
        check("t1_s5_lane3", lane(3), 8);
        step = 1'b0;
        tick();
        check("t1_hold_valid", out_valid, 4'b1000);
        check("t1_hold_lane3", lane(3), 8);

        // 2: fill to full, overflow refused, no bypass on push+step at full
        wr_valid = 1'b1;
        for (int k = 0; k < DP; k++) begin
            wr_data = vec(10 + k, 10 + k, 10 + k, 10 + k);
            tick();
        end
        check("t2_full_count", count, 8);
        check("t2_full_ready", wr_ready, 0);
        wr_data = vec(99, 99, 99, 99); tick();
        check("t2_ovf_count", count, 8);
        step = 1'b1; tick();
        wr_valid = 1'b0; step = 1'b0;
        check("t2_pushstep_count", count, 7);
        check("t2_pushstep_ready", wr_ready, 1);
        check("t2_first_out", lane(0), 10);

        // 3: empty-FIFO step injects a bubble while the pipe keeps shifting
        flush = 1'b1; tick(); flush = 1'b0;
        check("t3_flush_count", count, 0);
        wr_valid = 1'b1; wr_data = vec(11, 22, 33, 44); tick(); wr_valid = 1'b0;
        step = 1'b1; tick();
        check("t3_pop_lane0", lane(0), 11);
        tick();
        check("t3_bubble_valid", out_valid, 4'b0010);
        check("t3_bubble_zero", out_zero, 4'b0000);
        check("t3_lane1_shift", lane(1), 22);
        step = 1'b0;

        // 4: zero mask follows lanes 0 and 2 on their skewed cycles
        flush = 1'b1; tick(); flush = 1'b0;
        wr_valid = 1'b1; wr_data = vec(0, 9, 0, 3); tick(); wr_valid = 1'b0;
        step = 1'b1; tick();
        check("t4_s1_zero", out_zero, 4'b0001);
        check("t4_s1_valid", out_valid, 4'b0001);
        tick();
        check("t4_s2_zero", out_zero, 4'b0000);
        check("t4_s2_lane1", lane(1), 9);
        tick();
        check("t4_s3_zero", out_zero, 4'b0100);
        check("t4_s3_valid", out_valid, 4'b0100);
        tick();
        check("t4_s4_zero", out_zero, 4'b0000);
        check("t4_s4_lane3", lane(3), 3);
        step = 1'b0;

        // 5: all-zero writes
        flush = 1'b1; tick(); flush = 1'b0;
        wr_valid = 1'b1; wr_data = '0;
        tick(); tick(); tick();
        wr_data = vec(1, 1, 1, 1); tick(); wr_valid = 1'b0;
        check("t5_ready", wr_ready, 1);
`ifdef ZERO_SKIP_EN
        check("t5_count", count, 1);
        check("t5_skip", skip_cnt, 3);
`else
        check("t5_count", count, 4);
        check("t5_skip", skip_cnt, 0);
`endif

        // 6: flush with 5 stored entries and a full skew pipe
        flush = 1'b1; tick(); flush = 1'b0;
        wr_valid = 1'b1;
        for (int k = 0; k < DP; k++) begin
            wr_data = vec(50 + k, 50 + k, 50 + k, 50 + k);
            tick();
        end
        wr_valid = 1'b0; step = 1'b1;
        tick(); tick(); tick(); tick();
        step = 1'b0;
        wr_valid = 1'b1; wr_data = vec(70, 70, 70, 70); tick(); wr_valid = 1'b0;
        check("t6_pre_count", count, 5);
        check("t6_pre_valid", out_valid, 4'b1111);
        check("t6_pre_lane3", lane(3), 50);
        flush = 1'b1; wr_valid = 1'b1; step = 1'b1; tick();
        flush = 1'b0; wr_valid = 1'b0; step = 1'b0;
        check("t6_flush_count", count, 0);
        check("t6_flush_valid", out_valid, 4'b0000);
        check("t6_flush_ready", wr_ready, 1);
`ifdef ZERO_SKIP_EN
        check("t6_flush_skip", skip_cnt, 3);
`else
        check("t6_flush_skip", skip_cnt, 0);
`endif
        nRST = 1'b0; tick(); nRST = 1'b1;
        check("t6_rst_skip", skip_cnt, 0);
        check("t6_rst_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
